// File: rtl/fifo_uart_tx.sv
// Serial drain stage behind synchronous_fifo: pops one word per frame and shifts it out
// LSB-first as start / DATA_WIDTH data / STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  tx_en,
    output logic                  r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t                r_state, w_next;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_baud_last, w_data_last, w_stop_last, w_timed;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_data_last = w_baud_last && (r_bit == DATA_LAST);
    assign w_stop_last = w_baud_last && (r_bit == STOP_LAST);
    assign w_timed     = (r_state == START) || (r_state == DATA) || (r_state == STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            if (w_timed && !w_baud_last)
                r_baud <= r_baud + BAUD_W'(1);
            else
                r_baud <= '0;
            // Bit counter is shared by DATA and STOP; it restarts on every state change.
            if (w_next != r_state)
                r_bit <= '0;
            else if (w_baud_last && ((r_state == DATA) || (r_state == STOP)))
                r_bit <= r_bit + BIT_W'(1);
            if (r_state == LOAD)
                r_shift <= fifo_data;
            else if ((r_state == DATA) && w_baud_last)
                r_shift <= r_shift >> 1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (tx_en && !empty) w_next = FETCH;
            FETCH:   w_next = LOAD;
            LOAD:    w_next = START;
            START:   if (w_baud_last) w_next = DATA;
            DATA:    if (w_data_last) w_next = STOP;
            STOP:    if (w_stop_last) w_next = (tx_en && !empty) ? FETCH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs: async reset forces IDLE, so tx goes high immediately.
    assign r_en       = (r_state == FETCH);
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == STOP) && w_stop_last;
    assign tx         = (r_state == START) ? 1'b0 :
                        (r_state == DATA)  ? r_shift[0] : 1'b1;
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Serial drain stage directly downstream of synchronous_fifo. Watches the FIFO empty flag and pops one word at a time with r_en. It transmits each word LSB-first as an asynchronous serial frame: start bit, DATA_WIDTH data bits, then STOP_BITS stop bits. It owns the FIFO read side and is the last stage before the pad.

Parameters:
DATA_WIDTH, 8, word width; matches FIFO data_out width
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >=1
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after r_en is sampled
tx_en  input  1  1 = allowed to start new frames
r_en  output  1  FIFO read strobe; one-cycle pulse per word
tx  output  1  serial line; idles high
busy  output  1  1 in every state except IDLE
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx=1, r_en=0, busy=0, frame_done=0, all counters 0. Shift register is cleared.
- All outputs are registered or Moore-decoded from the state. No combinational path from empty or tx_en to any output.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: tx=1. If tx_en=1 and empty=0 at the clock edge, go to FETCH. Otherwise stay.
- FETCH: exactly 1 cycle with r_en=1. The FIFO samples r_en at the next edge. Go to LOAD.
- LOAD: exactly 1 cycle, r_en=0. fifo_data is valid here and is captured into the shift register at the end of the cycle. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0]. After each CLKS_PER_BIT cycles, shift right by 1. After DATA_WIDTH bits, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 on the final cycle. At the end of STOP:
  - if tx_en=1 and empty=0, go to FETCH (skip IDLE);
  - otherwise go to IDLE.
- Latency: the edge that samples empty=0 in IDLE leads to FETCH. tx falls at the start of the 3rd cycle after that edge.
- Back-to-back frames: exactly 2 tx-high gap cycles (FETCH, LOAD) between the stop-bit end and the next start bit.
- Frame length: (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- Counters:
  - baud counter is $clog2(CLKS_PER_BIT) bits, min 1, and counts 0..CLKS_PER_BIT-1;
  - bit counter is $clog2(DATA_WIDTH)+1 bits.
  - Neither counter ever wraps mid-bit.
- empty and tx_en are sampled only in IDLE and on the last STOP cycle; changes at other times are ignored.
- tx_en=0 mid-frame: the current frame completes normally, then the block goes to IDLE.
- Exactly one r_en pulse per transmitted word. r_en is never asserted when empty=1 was sampled. No read is issued while a frame is in flight.
- Reset mid-frame: tx returns to 1 immediately (async). The in-flight word is dropped and is not re-read.
- CLKS_PER_BIT=1: each bit lasts 1 cycle; the FSM timing above still holds.

Test Plan:
1. Assert rst_n=0 for 2 cycles with empty=0 -> tx=1, r_en=0, busy=0, frame_done=0 throughout; no FIFO read.
2. DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, one word 0xA5, tx_en=1 -> single r_en pulse. tx shows:
   - 0 for 4 cycles (start bit);
   - bits 1,0,1,0,0,1,0,1, 4 cycles each;
   - 1 for 4 cycles (stop bit);
   - frame_done on cycle 40 of the frame; busy=0 afterwards.
3. Words 0x00 then 0xFF queued -> two r_en pulses. Exactly 2 tx-high cycles between the first stop end and the second start. Second frame data bits all 1; busy stays 1 across the gap.
4. tx_en=0 with empty=0 for 10 cycles -> no r_en, tx=1. Raise tx_en -> FETCH (r_en=1) on the next cycle, start bit 2 cycles later.
5. rst_n pulsed low during data bit 3 of 0x3C -> tx=1 within the same cycle, busy=0. After release with empty=1: stays IDLE and no extra r_en.
6. STOP_BITS=2, CLKS_PER_BIT=4, word 0x81 -> stop phase lasts 8 cycles, frame length 44 cycles, frame_done on cycle 44.
